program_encoder: RTL and testbench

Assembles symbolic instruction requests into 32-bit instruction words in the pipeline's own encoding and writes them into instruction memory, one word per accepted request. It is the encode side of the ID-stage control decode: every word it emits must decode back to the requested operation. The block sits beside instruction memory and loads test and boot programs into it before the pipeline is released. A finish request appends a terminating branch-to-self.

---
 rtl/program_encoder_pkg.sv | 50 +++++
 rtl/instr_word_packer.sv | 51 +++++
 rtl/program_encoder.sv | 117 +++++++++++
 tb/tb_program_encoder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_encoder_pkg.sv
// Shared encoding constants for the program loader and the ID-stage control decode.
// Holds the symbolic request ops, instruction opcodes, mode bits and fixed words.
package program_encoder_pkg;

  typedef enum logic [3:0] {
    OP_MOV = 4'd0,  OP_MVN = 4'd1,  OP_ADD = 4'd2,  OP_ADC = 4'd3,
    OP_SUB = 4'd4,  OP_SBC = 4'd5,  OP_AND = 4'd6,  OP_ORR = 4'd7,
    OP_EOR = 4'd8,  OP_CMP = 4'd9,  OP_TST = 4'd10, OP_LDR = 4'd11,
    OP_STR = 4'd12, OP_B   = 4'd13, OP_NOP = 4'd14
  } op_e;

  localparam logic [3:0] OPC_AND = 4'b0000;
  localparam logic [3:0] OPC_EOR = 4'b0001;
  localparam logic [3:0] OPC_SUB = 4'b0010;
  localparam logic [3:0] OPC_ADD = 4'b0100;
  localparam logic [3:0] OPC_ADC = 4'b0101;
  localparam logic [3:0] OPC_SBC = 4'b0110;
  localparam logic [3:0] OPC_TST = 4'b1000;
  localparam logic [3:0] OPC_CMP = 4'b1010;
  localparam logic [3:0] OPC_ORR = 4'b1100;
  localparam logic [3:0] OPC_MOV = 4'b1101;
  localparam logic [3:0] OPC_MVN = 4'b1111;

  localparam logic [1:0] MODE_DP     = 2'b00;
  localparam logic [1:0] MODE_MEM    = 2'b01;
  localparam logic [1:0] MODE_BRANCH = 2'b10;

  localparam logic [31:0] NOP_WORD  = 32'hE1A0_0000;
  localparam logic [31:0] TERM_WORD = 32'hEAFF_FFFE;

  typedef enum logic [1:0] {ST_RUN, ST_TERM, ST_DONE} state_e;

  function automatic logic [3:0] dp_opcode(input op_e op);
    case (op)
      OP_MOV:  return OPC_MOV;
      OP_MVN:  return OPC_MVN;
      OP_ADD:  return OPC_ADD;
      OP_ADC:  return OPC_ADC;
      OP_SUB:  return OPC_SUB;
      OP_SBC:  return OPC_SBC;
      OP_AND:  return OPC_AND;
      OP_ORR:  return OPC_ORR;
      OP_EOR:  return OPC_EOR;
      OP_CMP:  return OPC_CMP;
      OP_TST:  return OPC_TST;
      default: return OPC_AND;
    endcase
  endfunction

endpackage

// File: rtl/instr_word_packer.sv
// Combinational packer: symbolic request fields in, 32-bit instruction word out.
// Op code 15 has no encoding and is flagged illegal.
module instr_word_packer
  import program_encoder_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [3:0]  cond,
  input  logic        set_status,
  input  logic        imm,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [11:0] operand2,
  input  logic [23:0] branch_offset,
  output logic [31:0] word,
  output logic        illegal
);

  op_e  op_sym;
  logic s_bit;
  logic [3:0] rd_field;

  assign op_sym = op_e'(op);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    word     = '0;
    illegal  = 1'b0;
    s_bit    = set_status;
    rd_field = rd;
    case (op_sym)
      OP_MOV, OP_MVN, OP_ADD, OP_ADC, OP_SUB, OP_SBC,
      OP_AND, OP_ORR, OP_EOR, OP_CMP, OP_TST: begin
        // Compare/test only update flags, so S is mandatory and Rd is unused.
        if (op_sym == OP_CMP || op_sym == OP_TST) begin
          s_bit    = 1'b1;
          rd_field = 4'd0;
        end
        word = {cond, MODE_DP, imm, dp_opcode(op_sym), s_bit, rn, rd_field, operand2};
      end
      OP_LDR, OP_STR:
        word = {cond, MODE_MEM, imm, OPC_ADD, (op_sym == OP_LDR), rn, rd, operand2};
      OP_B:
        word = {cond, MODE_BRANCH, 1'b1, 1'b0, branch_offset};
      OP_NOP:
        word = NOP_WORD;
      default:
        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/program_encoder.sv
// Loads encoded programs into instruction memory, one word per accepted request,
// and appends a branch-to-self terminator when asked to finish.
module program_encoder
  import program_encoder_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic                       i_Clear,
  input  logic                       i_Req_Valid,
  output logic                       o_Req_Ready,
  input  logic [3:0]                 i_Req_Op,
  input  logic [3:0]                 i_Req_Cond,
  input  logic                       i_Req_Set_Status,
  input  logic                       i_Req_Imm,
  input  logic [3:0]                 i_Req_Rn,
  input  logic [3:0]                 i_Req_Rd,
  input  logic [11:0]                i_Req_Operand2,
  input  logic [23:0]                i_Req_Branch_Offset,
  input  logic                       i_Finish,
  output logic                       o_Mem_Write_Enable,
  output logic [31:0]                o_Mem_Address,
  output logic [31:0]                o_Mem_Write_Data,
  output logic [$clog2(DEPTH):0]     o_Word_Count,
  output logic                       o_Full,
  output logic                       o_Done,
  output logic                       o_Error
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e      state, state_next;
  logic [31:0] packed_word, write_word;
  logic        illegal, accept, write_req, error_set;

  instr_word_packer u_packer (
    .op            (i_Req_Op),
    .cond          (i_Req_Cond),
    .set_status    (i_Req_Set_Status),
    .imm           (i_Req_Imm),
    .rn            (i_Req_Rn),
    .rd            (i_Req_Rd),
    .operand2      (i_Req_Operand2),
    .branch_offset (i_Req_Branch_Offset),
    .word          (packed_word),
    .illegal       (illegal)
  );

  assign o_Full      = (o_Word_Count == CW'(DEPTH));
  assign o_Done      = (state == ST_DONE);
  assign o_Req_Ready = (state == ST_RUN) && !o_Full && !i_Reset;
  assign accept      = i_Req_Valid && o_Req_Ready;

  always_comb begin
    state_next = state;
    write_req  = 1'b0;
    write_word = packed_word;
    error_set  = 1'b0;
    case (state)
      ST_RUN: begin
        if (accept) begin
          if (illegal) error_set = 1'b1;
          else         write_req = 1'b1;
        end
        if (i_Finish) begin
          if (o_Full) begin
            error_set  = 1'b1;
            state_next = ST_DONE;
          end else begin
            state_next = ST_TERM;
          end
        end
      end
      ST_TERM: begin
        // A same-edge final request may have filled memory; no room for the terminator.
        if (o_Full) begin
          error_set = 1'b1;
        end else begin
          write_req  = 1'b1;
          write_word = TERM_WORD;
        end
        state_next = ST_DONE;
      end
      default: state_next = ST_DONE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state              <= ST_RUN;
      o_Mem_Write_Enable <= 1'b0;
      o_Mem_Address      <= '0;
      o_Mem_Write_Data   <= '0;
      o_Word_Count       <= '0;
      o_Error            <= 1'b0;
    end else begin
      o_Mem_Write_Enable <= 1'b0;
      if (i_Clear) begin
        state        <= ST_RUN;
        o_Word_Count <= '0;
        o_Error      <= 1'b0;
      end else begin
        state <= state_next;
        if (write_req) begin
          o_Mem_Write_Enable <= 1'b1;
          o_Mem_Address      <= 32'(o_Word_Count) << 2;
          o_Mem_Write_Data   <= write_word;
          o_Word_Count       <= o_Word_Count + 1'b1;
        end
        if (error_set) o_Error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_program_encoder.sv
// Self-checking bench for program_encoder: encoding table, multi-cycle sequences,
// a small-DEPTH instance for full/finish corners, and a random run against a reference model.
module tb_program_encoder;
  import program_encoder_pkg::*;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  cond;
    logic        s;
    logic        imm;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] op2;
    logic [23:0] boff;
  } req_t;

  typedef struct {
    req_t        req;
    logic [31:0] word;
  } vec_t;

  logic clk = 1'b0;
  logic rst, clr, valid, finish;
  logic [3:0]  op, cond, rn, rd;
  logic        s, imm;
  logic [11:0] op2;
  logic [23:0] boff;

  logic        rdy_b, we_b, full_b, done_b, err_b;
  logic [31:0] addr_b, data_b;
  logic [8:0]  cnt_b;
  logic        rdy_s, we_s, full_s, done_s, err_s;
  logic [31:0] addr_s, data_s;
  logic [2:0]  cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  program_encoder #(.DEPTH(256)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Clear(clr), .i_Req_Valid(valid), .o_Req_Ready(rdy_b),
    .i_Req_Op(op), .i_Req_Cond(cond), .i_Req_Set_Status(s), .i_Req_Imm(imm),
    .i_Req_Rn(rn), .i_Req_Rd(rd), .i_Req_Operand2(op2), .i_Req_Branch_Offset(boff),
    .i_Finish(finish), .o_Mem_Write_Enable(we_b), .o_Mem_Address(addr_b),
    .o_Mem_Write_Data(data_b), .o_Word_Count(cnt_b), .o_Full(full_b), .o_Done(done_b),
    .o_Error(err_b)
  );

  program_encoder #(.DEPTH(4)) dut_small (
    .i_Clock(clk), .i_Reset(rst), .i_Clear(clr), .i_Req_Valid(valid), .o_Req_Ready(rdy_s),
    .i_Req_Op(op), .i_Req_Cond(cond), .i_Req_Set_Status(s), .i_Req_Imm(imm),
    .i_Req_Rn(rn), .i_Req_Rd(rd), .i_Req_Operand2(op2), .i_Req_Branch_Offset(boff),
    .i_Finish(finish), .o_Mem_Write_Enable(we_s), .o_Mem_Address(addr_s),
    .o_Mem_Write_Data(data_s), .o_Word_Count(cnt_s), .o_Full(full_s), .o_Done(done_s),
    .o_Error(err_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference encoder built directly from the field-layout rules with shifts and adds.
  function automatic logic [31:0] ref_encode(input req_t r);
    int unsigned dp_code[11] = '{13, 15, 4, 5, 2, 6, 0, 12, 1, 10, 8};
    int unsigned w, sb, rdv;
    int unsigned o = int'(r.op);
    if (o <= 10) begin
      sb  = r.s;
      rdv = r.rd;
      if (o == 9 || o == 10) begin sb = 1; rdv = 0; end
      w = r.cond * (2**28) + r.imm * (2**25) + dp_code[o] * (2**21) + sb * (2**20)
        + r.rn * (2**16) + rdv * (2**12) + r.op2;
    end else if (o == 11 || o == 12) begin
      w = r.cond * (2**28) + (2**26) + r.imm * (2**25) + 4 * (2**21)
        + ((o == 11) ? (2**20) : 0) + r.rn * (2**16) + r.rd * (2**12) + r.op2;
    end else if (o == 13) begin
      w = r.cond * (2**28) + 5 * (2**25) + r.boff;
    end else begin
      w = 32'hE1A00000;
    end
    return w;
  endfunction

  task automatic drive(input req_t r, input logic v);
    op = r.op; cond = r.cond; s = r.s; imm = r.imm;
    rn = r.rn; rd = r.rd; op2 = r.op2; boff = r.boff; valid = v;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    valid = 1'b0; finish = 1'b0; clr = 1'b0;
    rst = 1'b1;
    #3;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  vec_t vecs[10];
  req_t r;
  req_t add_req;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{'{OP_ADD, 4'hE, 1'b0, 1'b1, 4'd2, 4'd1, 12'h005, 24'h0}, 32'hE2821005};
    vecs[1] = '{'{OP_CMP, 4'hE, 1'b0, 1'b0, 4'd1, 4'd0, 12'h002, 24'h0}, 32'hE1510002};
    vecs[2] = '{'{OP_LDR, 4'hE, 1'b0, 1'b0, 4'd1, 4'd0, 12'h004, 24'h0}, 32'hE4910004};
    vecs[3] = '{'{OP_STR, 4'hE, 1'b0, 1'b0, 4'd1, 4'd0, 12'h004, 24'h0}, 32'hE4810004};
    vecs[4] = '{'{OP_NOP, 4'h0, 1'b1, 1'b1, 4'd3, 4'd3, 12'hFFF, 24'h0}, 32'hE1A00000};
    vecs[5] = '{'{OP_B,   4'hE, 1'b0, 1'b0, 4'd0, 4'd0, 12'h000, 24'h000010}, 32'hEA000010};
    vecs[6] = '{'{OP_MOV, 4'hE, 1'b1, 1'b1, 4'd0, 4'd3, 12'h0FF, 24'h0}, 32'hE3B030FF};
    vecs[7] = '{'{OP_TST, 4'h0, 1'b0, 1'b1, 4'd4, 4'd5, 12'h001, 24'h0}, 32'h03140001};
    vecs[8] = '{'{OP_SUB, 4'h1, 1'b1, 1'b0, 4'd7, 4'd8, 12'h123, 24'h0}, 32'h10578123};
    vecs[9] = '{'{OP_EOR, 4'hE, 1'b0, 1'b0, 4'd1, 4'd2, 12'h003, 24'h0}, 32'hE0212003};
    add_req = vecs[0].req;

    drive(add_req, 1'b0);
    finish = 1'b0; clr = 1'b0; rst = 1'b1;
    #3;
    check("reset_we", 32'(we_b), 0);
    check("reset_addr", addr_b, 0);
    check("reset_data", data_b, 0);
    check("reset_count", 32'(cnt_b), 0);
    check("reset_flags", {29'd0, full_b, done_b, err_b}, 0);
    tick();
    rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(rdy_b), 1);

    // Encoding table, written back to back
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].req, 1'b1);
      tick();
      check($sformatf("tbl%0d_we", i), 32'(we_b), 1);
      check($sformatf("tbl%0d_addr", i), addr_b, 32'(i * 4));
      check($sformatf("tbl%0d_data", i), data_b, vecs[i].word);
      check($sformatf("tbl%0d_count", i), 32'(cnt_b), 32'(i + 1));
    end
    valid = 1'b0;
    tick();
    check("idle_we", 32'(we_b), 0);

    // Three requests, finish on the third accept, terminator follows
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(vecs[i].req, 1'b1);
      finish = (i == 2);
      tick();
      check($sformatf("seq%0d_addr", i), addr_b, 32'(i * 4));
      check($sformatf("seq%0d_data", i), data_b, vecs[i].word);
    end
    valid = 1'b1; finish = 1'b0;
    tick();
    check("term_we", 32'(we_b), 1);
    check("term_addr", addr_b, 32'd12);
    check("term_data", data_b, 32'hEAFFFFFE);
    check("term_count", 32'(cnt_b), 4);
    check("term_done", 32'(done_b), 1);
    check("done_ready", 32'(rdy_b), 0);
    tick();
    check("done_no_write", 32'(we_b), 0);
    check("done_count_held", 32'(cnt_b), 4);
    valid = 1'b0;

    // Illegal op and sticky error
    do_reset();
    r = add_req; r.op = 4'd15;
    drive(r, 1'b1);
    tick();
    check("illegal_we", 32'(we_b), 0);
    check("illegal_err", 32'(err_b), 1);
    check("illegal_count", 32'(cnt_b), 0);
    drive(add_req, 1'b1);
    tick();
    check("after_illegal_write", 32'(we_b), 1);
    check("after_illegal_addr", addr_b, 0);
    check("err_sticky", 32'(err_b), 1);

    // Reset mid-stream clears outputs asynchronously
    tick();
    check("midstream_we", 32'(we_b), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_we", 32'(we_b), 0);
    check("async_addr", addr_b, 0);
    check("async_data", data_b, 0);
    check("async_count", 32'(cnt_b), 0);
    check("async_err", 32'(err_b), 0);
    check("async_ready", 32'(rdy_b), 0);
    tick();
    rst = 1'b0; valid = 1'b0;

    // DEPTH=4 instance: fill, stall, finish at full, clear
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(vecs[i].req, 1'b1);
      tick();
      check($sformatf("small%0d_addr", i), addr_s, 32'(i * 4));
    end
    check("small_full", 32'(full_s), 1);
    check("small_ready", 32'(rdy_s), 0);
    check("small_count", 32'(cnt_s), 4);
    tick();
    check("small_stall_we", 32'(we_s), 0);
    check("small_stall_count", 32'(cnt_s), 4);
    valid = 1'b0; finish = 1'b1;
    tick();
    finish = 1'b0;
    check("full_finish_err", 32'(err_s), 1);
    check("full_finish_we", 32'(we_s), 0);
    check("full_finish_done", 32'(done_s), 1);
    tick();
    check("full_finish_no_term", 32'(we_s), 0);
    check("full_finish_count", 32'(cnt_s), 4);
    drive(add_req, 1'b1); clr = 1'b1;
    tick();
    clr = 1'b0; valid = 1'b0;
    check("clear_count", 32'(cnt_s), 0);
    check("clear_flags", {29'd0, full_s, done_s, err_s}, 0);
    check("clear_no_write", 32'(we_s), 0);
    check("clear_ready", 32'(rdy_s), 1);

    // Random stream against the reference model
    do_reset();
    begin
      int unsigned exp_cnt = 0;
      logic exp_err = 1'b0;
      for (int n = 0; n < 300; n++) begin
        r.op   = ($urandom_range(0, 15) == 15) ? 4'd15 : 4'($urandom_range(0, 14));
        r.cond = 4'($urandom); r.s = 1'($urandom); r.imm = 1'($urandom);
        r.rn = 4'($urandom); r.rd = 4'($urandom); r.op2 = 12'($urandom);
        r.boff = 24'($urandom);
        drive(r, 1'($urandom_range(0, 3) != 0));
        tick();
        if (valid && r.op == 4'd15) begin
          exp_err = 1'b1;
          check("rnd_illegal_we", 32'(we_b), 0);
        end else if (valid) begin
          check("rnd_we", 32'(we_b), 1);
          check("rnd_addr", addr_b, exp_cnt * 4);
          check("rnd_data", data_b, ref_encode(r));
          exp_cnt++;
        end else begin
          check("rnd_idle_we", 32'(we_b), 0);
        end
        check("rnd_count", 32'(cnt_b), exp_cnt);
        check("rnd_err", 32'(err_b), 32'(exp_err));
      end
    end
    valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
